lockstep_sequencer: RTL and testbench

Controller that sequences the dual-core lockstep datapath: halt both cores, resynchronise them, then supervise comparator results.
Configured and observed through a 32-bit peripheral slave port using the cluster's req/gnt/r_valid/id protocol.
Sits beside the lockstep comparator on the cluster peripheral interconnect.
Drives halt/resume to the core pair, enables comparison and raises a sticky error interrupt.

---
 rtl/lockstep_pkg.sv | 47 ++++
 rtl/lockstep_regif.sv | 110 +++++++++++
 rtl/lockstep_sequencer.sv | 155 +++++++++++++++
 tb/tb_lockstep_sequencer.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lockstep_pkg                                                         |
// | Shared types, register map and helpers for the lockstep sequencer.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lockstep_pkg;

    // Encoding is visible to software through STATUS[1:0].
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_HALT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    localparam logic [31:0] c_default_base_addr = 32'h1020_2800;

    localparam logic [31:0] c_offs_ctrl   = 32'h0000_0000;
    localparam logic [31:0] c_offs_status = 32'h0000_0004;
    localparam logic [31:0] c_offs_tmo    = 32'h0000_0008;

    localparam int c_ctrl_en_bit      = 0;
    localparam int c_ctrl_clr_bit     = 1;
    localparam int c_status_err_bit   = 8;
    localparam int c_status_cause_bit = 9;
    localparam int c_status_cnt_lsb   = 16;

    typedef struct packed {
        state_e      state;
        logic        err;
        logic        cause;
        logic [15:0] mis_cnt;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] v;
        v                              = '0;
        v[1:0]                         = s.state;
        v[c_status_err_bit]            = s.err;
        v[c_status_cause_bit]          = s.cause;
        v[c_status_cnt_lsb +: 16]      = s.mis_cnt;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lockstep_regif.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lockstep_regif                                                       |
// | Peripheral slave decode, CTRL/TMO registers and response pipeline.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lockstep_regif
    import lockstep_pkg::*;
#(
    parameter int          ID_WIDTH  = 5,
    parameter logic [31:0] BASE_ADDR = c_default_base_addr,
    parameter int          TMO_W     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [31:0]         addr_i,
    input  logic                wen_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          be_i,
    input  logic [ID_WIDTH-1:0] id_i,
    output logic                gnt_o,
    output logic                r_valid_o,
    output logic                r_opc_o,
    output logic [ID_WIDTH-1:0] r_id_o,
    output logic [31:0]         r_rdata_o,
    output logic                en_o,
    output logic                clr_err_o,
    output logic [TMO_W-1:0]    tmo_o,
    input  status_t             status_i
);

    logic                w_wr;
    logic                w_rd;
    logic                w_sel_ctrl;
    logic                w_sel_status;
    logic                w_sel_tmo;
    logic [31:0]         w_rdata;
    logic [TMO_W-1:0]    w_tmo_next;
    logic                w_unused_ok;

    logic                r_en;
    logic                r_clr_err;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_rdata;

    assign w_wr         = req_i & ~wen_i;
    assign w_rd         = req_i &  wen_i;
    assign w_sel_ctrl   = (addr_i == BASE_ADDR + c_offs_ctrl);
    assign w_sel_status = (addr_i == BASE_ADDR + c_offs_status);
    assign w_sel_tmo    = (addr_i == BASE_ADDR + c_offs_tmo);

    // Only part of the write data / byte enables reaches a register.
    assign w_unused_ok  = ^{wdata_i, be_i};

    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl) begin
            w_rdata[c_ctrl_en_bit] = r_en;
        end else if (w_sel_status) begin
            w_rdata = pack_status(status_i);
        end else if (w_sel_tmo) begin
            w_rdata[TMO_W-1:0] = r_tmo;
        end
    end

    always_comb begin
        w_tmo_next = r_tmo;
        for (int i = 0; i < TMO_W; i++) begin
            if (be_i[i[4:3]]) begin
                w_tmo_next[i] = wdata_i[i[4:0]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en      <= 1'b0;
            r_clr_err <= 1'b0;
            r_tmo     <= '1;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_rdata   <= '0;
        end else begin
            r_valid   <= req_i;
            r_id      <= id_i;
            r_rdata   <= w_rd ? w_rdata : 32'h0;
            r_clr_err <= w_wr & w_sel_ctrl & be_i[0] & wdata_i[c_ctrl_clr_bit];
            if (w_wr && w_sel_ctrl && be_i[0]) begin
                r_en <= wdata_i[c_ctrl_en_bit];
            end
            if (w_wr && w_sel_tmo) begin
                r_tmo <= w_tmo_next;
            end
        end
    end

    assign gnt_o     = 1'b1;
    assign r_opc_o   = 1'b0;
    assign r_valid_o = r_valid;
    assign r_id_o    = r_id;
    assign r_rdata_o = r_rdata;
    assign en_o      = r_en;
    assign clr_err_o = r_clr_err;
    assign tmo_o     = r_tmo;

endmodule
`default_nettype wire

// File: rtl/lockstep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lockstep_sequencer                                                   |
// | Halts and resynchronises the core pair, then supervises comparison.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lockstep_sequencer
    import lockstep_pkg::*;
#(
    parameter int          ID_WIDTH  = 5,
    parameter logic [31:0] BASE_ADDR = 32'h1020_2800,
    parameter int          TMO_W     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [31:0]         addr_i,
    input  logic                wen_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          be_i,
    input  logic [ID_WIDTH-1:0] id_i,
    output logic                gnt_o,
    output logic                r_valid_o,
    output logic                r_opc_o,
    output logic [ID_WIDTH-1:0] r_id_o,
    output logic [31:0]         r_rdata_o,
    output logic [1:0]          halt_req_o,
    input  logic [1:0]          halted_i,
    output logic                resume_o,
    input  logic                cmp_valid_i,
    input  logic                cmp_mismatch_i,
    output logic                lockstep_en_o,
    output logic                err_irq_o
);

    logic             w_en;
    logic             w_clr_err;
    logic [TMO_W-1:0] w_tmo;
    logic             w_hit;
    status_t          w_status;

    state_e           r_state;
    logic [TMO_W-1:0] r_cnt;
    logic             r_err;
    logic             r_cause;
    logic [15:0]      r_mis_cnt;

    lockstep_regif #(
        .ID_WIDTH  (ID_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .TMO_W     (TMO_W)
    ) u_regif (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .wen_i     (wen_i),
        .wdata_i   (wdata_i),
        .be_i      (be_i),
        .id_i      (id_i),
        .gnt_o     (gnt_o),
        .r_valid_o (r_valid_o),
        .r_opc_o   (r_opc_o),
        .r_id_o    (r_id_o),
        .r_rdata_o (r_rdata_o),
        .en_o      (w_en),
        .clr_err_o (w_clr_err),
        .tmo_o     (w_tmo),
        .status_i  (w_status)
    );

    assign w_status.state   = r_state;
    assign w_status.err     = r_err;
    assign w_status.cause   = r_cause;
    assign w_status.mis_cnt = r_mis_cnt;

    // A mismatch only counts while locked, even on the cycle EN drops.
    assign w_hit = (r_state == ST_LOCKED) & cmp_valid_i & cmp_mismatch_i;

    assign err_irq_o = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_OFF;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            r_cause       <= 1'b0;
            r_mis_cnt     <= '0;
            halt_req_o    <= 2'b00;
            resume_o      <= 1'b0;
            lockstep_en_o <= 1'b0;
        end else begin
            resume_o <= 1'b0;
            if (w_hit && (r_mis_cnt != 16'hFFFF)) begin
                r_mis_cnt <= r_mis_cnt + 16'd1;
            end
            // Clear first so a simultaneous new error still wins.
            if (w_clr_err) begin
                r_err <= 1'b0;
            end
            if (!w_en) begin
                r_state       <= ST_OFF;
                halt_req_o    <= 2'b00;
                lockstep_en_o <= 1'b0;
                if (w_hit) begin
                    r_err   <= 1'b1;
                    r_cause <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state    <= ST_HALT;
                        r_cnt      <= w_tmo;
                        halt_req_o <= 2'b11;
                    end
                    ST_HALT: begin
                        if (halted_i == 2'b11) begin
                            r_state       <= ST_LOCKED;
                            resume_o      <= 1'b1;
                            halt_req_o    <= 2'b00;
                            lockstep_en_o <= 1'b1;
                        end else if (r_cnt == '0) begin
                            r_state    <= ST_ERROR;
                            r_err      <= 1'b1;
                            r_cause    <= 1'b1;
                            halt_req_o <= 2'b00;
                        end else begin
                            r_cnt <= r_cnt - TMO_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (w_hit) begin
                            r_state       <= ST_ERROR;
                            r_err         <= 1'b1;
                            r_cause       <= 1'b0;
                            lockstep_en_o <= 1'b0;
                        end
                    end
                    ST_ERROR: begin
                        if (w_clr_err) begin
                            r_state    <= ST_HALT;
                            r_cnt      <= w_tmo;
                            halt_req_o <= 2'b11;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lockstep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lockstep_sequencer                                                |
// | Directed scenarios plus random traffic against a behavioural model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lockstep_sequencer;

    localparam logic [31:0] c_base    = 32'h1020_2800;
    localparam logic [31:0] c_a_ctrl  = c_base + 32'h0;
    localparam logic [31:0] c_a_stat  = c_base + 32'h4;
    localparam logic [31:0] c_a_tmo   = c_base + 32'h8;
    localparam logic [31:0] c_a_unmap = c_base + 32'hC;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        wen_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic [4:0]  id_i = '0;
    logic        gnt_o;
    logic        r_valid_o;
    logic        r_opc_o;
    logic [4:0]  r_id_o;
    logic [31:0] r_rdata_o;
    logic [1:0]  halt_req_o;
    logic [1:0]  halted_i = 2'b00;
    logic        resume_o;
    logic        cmp_valid_i = 1'b0;
    logic        cmp_mismatch_i = 1'b0;
    logic        lockstep_en_o;
    logic        err_irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    lockstep_sequencer #(
        .ID_WIDTH  (5),
        .BASE_ADDR (c_base),
        .TMO_W     (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .addr_i         (addr_i),
        .wen_i          (wen_i),
        .wdata_i        (wdata_i),
        .be_i           (be_i),
        .id_i           (id_i),
        .gnt_o          (gnt_o),
        .r_valid_o      (r_valid_o),
        .r_opc_o        (r_opc_o),
        .r_id_o         (r_id_o),
        .r_rdata_o      (r_rdata_o),
        .halt_req_o     (halt_req_o),
        .halted_i       (halted_i),
        .resume_o       (resume_o),
        .cmp_valid_i    (cmp_valid_i),
        .cmp_mismatch_i (cmp_mismatch_i),
        .lockstep_en_o  (lockstep_en_o),
        .err_irq_o      (err_irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transfer starting at a falling edge; returns the response seen
    // at the following falling edge.
    task automatic bus_xfer(input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                            input logic [3:0] be, input logic [4:0] id,
                            output logic rv, output logic [4:0] rid, output logic [31:0] rd);
        req_i   = 1'b1;
        addr_i  = addr;
        wen_i   = wen;
        wdata_i = wd;
        be_i    = be;
        id_i    = id;
        @(negedge clk_i);
        rv      = r_valid_o;
        rid     = r_id_o;
        rd      = r_rdata_o;
        req_i   = 1'b0;
        wen_i   = 1'b0;
        wdata_i = '0;
        be_i    = '0;
    endtask

    // Behavioural model of the sequencer, stepped once per rising edge.
    int          m_mode, m_elapsed, m_limit, m_mis;
    bit          m_en, m_clr, m_err, m_cause;
    int          m_tmo;
    bit          e_resume, e_rvalid;
    logic [4:0]  e_rid;
    logic [31:0] e_rdata;

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_limit = 0; m_mis = 0;
        m_en = 0; m_clr = 0; m_err = 0; m_cause = 0; m_tmo = 255;
        e_resume = 0; e_rvalid = 0; e_rid = '0; e_rdata = '0;
    endtask

    task automatic model_step();
        bit hit, clr_next;
        e_rvalid = req_i;
        e_rid    = id_i;
        e_rdata  = '0;
        if (req_i && wen_i) begin
            if (addr_i == c_a_ctrl)      e_rdata = 32'(int'(m_en));
            else if (addr_i == c_a_stat) e_rdata = 32'(m_mis * 65536 + int'(m_cause) * 512 + int'(m_err) * 256 + m_mode);
            else if (addr_i == c_a_tmo)  e_rdata = 32'(m_tmo);
        end
        e_resume = 0;
        hit = (m_mode == 2) && cmp_valid_i && cmp_mismatch_i;
        if (hit && m_mis < 65535) m_mis++;
        if (m_clr) m_err = 0;
        if (!m_en) begin
            if (hit) begin m_err = 1; m_cause = 0; end
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_elapsed = 0; m_limit = m_tmo;
        end else if (m_mode == 1) begin
            if (halted_i == 2'b11) begin
                m_mode = 2; e_resume = 1;
            end else if (m_elapsed == m_limit) begin
                m_mode = 3; m_err = 1; m_cause = 1;
            end else begin
                m_elapsed++;
            end
        end else if (m_mode == 2) begin
            if (hit) begin m_mode = 3; m_err = 1; m_cause = 0; end
        end else begin
            if (m_clr) begin m_mode = 1; m_elapsed = 0; m_limit = m_tmo; end
        end
        clr_next = 0;
        if (req_i && !wen_i && be_i[0]) begin
            if (addr_i == c_a_ctrl) begin
                m_en     = wdata_i[0];
                clr_next = wdata_i[1];
            end else if (addr_i == c_a_tmo) begin
                m_tmo = int'(wdata_i[7:0]);
            end
        end
        m_clr = clr_next;
    endtask

    task automatic test_reset();
        logic rv; logic [4:0] rid; logic [31:0] rd;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({halt_req_o, resume_o, lockstep_en_o, err_irq_o, r_valid_o, r_opc_o, gnt_o} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_outputs: got halt=%b res=%b en=%b irq=%b rv=%b opc=%b gnt=%b, want 00 0 0 0 0 0 1",
                     halt_req_o, resume_o, lockstep_en_o, err_irq_o, r_valid_o, r_opc_o, gnt_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h0B, rv, rid, rd);
        n_checks++;
        if (rv !== 1'b1 || rid !== 5'h0B || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status_read: rv=%b id=%h data=%h, want 1 0b 00000000", rv, rid, rd);
        end
        n_checks++;
        @(negedge clk_i);
        if (r_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_response: r_valid=%b, want 0", r_valid_o);
        end
        bus_xfer(c_a_tmo, 1'b1, 32'h0, 4'h0, 5'h03, rv, rid, rd);
        n_checks++;
        if (rv !== 1'b1 || rid !== 5'h03 || rd !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL reset_tmo_read: rv=%b id=%h data=%h, want 1 03 000000ff", rv, rid, rd);
        end
    endtask

    task automatic test_byte_enable();
        logic rv; logic [4:0] rid; logic [31:0] rd;
        bus_xfer(c_a_ctrl, 1'b0, 32'h1, 4'h0, 5'h01, rv, rid, rd);
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (halt_req_o !== 2'b00 || lockstep_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL be0_no_start: halt=%b en=%b, want 00 0", halt_req_o, lockstep_en_o);
        end
        bus_xfer(c_a_ctrl, 1'b1, 32'h0, 4'h0, 5'h02, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL be0_ctrl_read: data=%h, want 00000000", rd);
        end
        bus_xfer(c_a_tmo, 1'b0, 32'h12, 4'h0, 5'h03, rv, rid, rd);
        bus_xfer(c_a_tmo, 1'b1, 32'h0, 4'h0, 5'h04, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL be0_tmo_kept: data=%h, want 000000ff", rd);
        end
        bus_xfer(c_a_unmap, 1'b0, 32'hFFFF_FFFF, 4'hF, 5'h05, rv, rid, rd);
        n_checks++;
        if (rv !== 1'b1 || rid !== 5'h05 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_write_resp: rv=%b id=%h data=%h, want 1 05 00000000", rv, rid, rd);
        end
        bus_xfer(c_a_unmap, 1'b1, 32'h0, 4'h0, 5'h1F, rv, rid, rd);
        n_checks++;
        if (rv !== 1'b1 || rid !== 5'h1F || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: rv=%b id=%h data=%h, want 1 1f 00000000", rv, rid, rd);
        end
        bus_xfer(c_a_stat, 1'b0, 32'hFFFF_FFFF, 4'hF, 5'h06, rv, rid, rd);
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h07, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL status_write_ignored: data=%h, want 00000000", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want_rd [4] = '{32'h0000_00FF, 32'h0, 32'h0, 32'h0000_005A};
        logic [31:0] addrs   [4] = '{c_a_tmo, c_a_ctrl, c_a_tmo, c_a_tmo};
        logic        wens    [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            req_i   = 1'b1;
            addr_i  = addrs[i];
            wen_i   = wens[i];
            wdata_i = 32'h0000_005A;
            be_i    = 4'hF;
            id_i    = 5'(i + 1);
            @(negedge clk_i);
            n_checks++;
            if (r_valid_o !== 1'b1 || r_id_o !== 5'(i + 1) || r_rdata_o !== want_rd[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: rv=%b id=%h data=%h, want 1 %h %h",
                         i, r_valid_o, r_id_o, r_rdata_o, 5'(i + 1), want_rd[i]);
            end
        end
        req_i = 1'b0; wen_i = 1'b0; be_i = '0; wdata_i = '0;
        @(negedge clk_i);
        n_checks++;
        if (r_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_end: r_valid=%b, want 0", r_valid_o);
        end
    endtask

    task automatic test_lock();
        logic rv; logic [4:0] rid; logic [31:0] rd;
        int k, pulses;
        bus_xfer(c_a_ctrl, 1'b0, 32'h1, 4'hF, 5'h01, rv, rid, rd);
        for (k = 0; k < 6 && halt_req_o !== 2'b11; k++) @(negedge clk_i);
        n_checks++;
        if (halt_req_o !== 2'b11 || k != 1) begin
            n_fail++;
            $display("FAIL lock_halt_req: halt=%b after %0d cycles, want 11 after 1", halt_req_o, k);
        end
        repeat (3) @(negedge clk_i);
        halted_i = 2'b11;
        @(negedge clk_i);
        halted_i = 2'b00;
        n_checks++;
        if (resume_o !== 1'b1 || halt_req_o !== 2'b00 || lockstep_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_resume: res=%b halt=%b en=%b, want 1 00 1", resume_o, halt_req_o, lockstep_en_o);
        end
        pulses = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (resume_o === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL lock_single_pulse: extra resume pulses=%0d, want 0", pulses);
        end
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h02, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0000_0002 || lockstep_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_status: data=%h en=%b, want 00000002 1", rd, lockstep_en_o);
        end
    endtask

    task automatic test_mismatch();
        logic rv; logic [4:0] rid; logic [31:0] rd;
        cmp_valid_i = 1'b1; cmp_mismatch_i = 1'b1;
        @(negedge clk_i);
        cmp_valid_i = 1'b0; cmp_mismatch_i = 1'b0;
        n_checks++;
        if (err_irq_o !== 1'b1 || lockstep_en_o !== 1'b0 || halt_req_o !== 2'b00) begin
            n_fail++;
            $display("FAIL mismatch_irq: irq=%b en=%b halt=%b, want 1 0 00", err_irq_o, lockstep_en_o, halt_req_o);
        end
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h03, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0001_0103) begin
            n_fail++;
            $display("FAIL mismatch_status: data=%h, want 00010103", rd);
        end
        cmp_valid_i = 1'b1; cmp_mismatch_i = 1'b1;
        @(negedge clk_i);
        cmp_valid_i = 1'b0; cmp_mismatch_i = 1'b0;
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h04, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0001_0103) begin
            n_fail++;
            $display("FAIL error_no_count: data=%h, want 00010103", rd);
        end
        bus_xfer(c_a_ctrl, 1'b0, 32'h3, 4'hF, 5'h05, rv, rid, rd);
        @(negedge clk_i);
        n_checks++;
        if (err_irq_o !== 1'b0 || halt_req_o !== 2'b11) begin
            n_fail++;
            $display("FAIL clr_err_rehalt: irq=%b halt=%b, want 0 11", err_irq_o, halt_req_o);
        end
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h06, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0001_0001) begin
            n_fail++;
            $display("FAIL clr_err_status: data=%h, want 00010001", rd);
        end
        bus_xfer(c_a_ctrl, 1'b1, 32'h0, 4'h0, 5'h07, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL ctrl_readback: data=%h, want 00000001", rd);
        end
        bus_xfer(c_a_ctrl, 1'b0, 32'h0, 4'hF, 5'h08, rv, rid, rd);
        @(negedge clk_i);
        n_checks++;
        if (halt_req_o !== 2'b00) begin
            n_fail++;
            $display("FAIL disable_off: halt=%b, want 00", halt_req_o);
        end
    endtask

    task automatic test_timeout();
        logic rv; logic [4:0] rid; logic [31:0] rd;
        int k, n;
        bus_xfer(c_a_tmo, 1'b0, 32'h4, 4'hF, 5'h01, rv, rid, rd);
        halted_i = 2'b01;
        bus_xfer(c_a_ctrl, 1'b0, 32'h1, 4'hF, 5'h02, rv, rid, rd);
        for (k = 0; k < 6 && halt_req_o !== 2'b11; k++) @(negedge clk_i);
        n = 0;
        while (halt_req_o === 2'b11 && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        n_checks++;
        if (n != 5 || err_irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_len: halt cycles=%0d irq=%b, want 5 1", n, err_irq_o);
        end
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h03, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0001_0303) begin
            n_fail++;
            $display("FAIL timeout_status: data=%h, want 00010303", rd);
        end
        bus_xfer(c_a_ctrl, 1'b0, 32'h2, 4'hF, 5'h04, rv, rid, rd);
        @(negedge clk_i);
        halted_i = 2'b00;
        n_checks++;
        if (err_irq_o !== 1'b0 || halt_req_o !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_clear: irq=%b halt=%b, want 0 00", err_irq_o, halt_req_o);
        end
    endtask

    task automatic test_tmo_zero();
        logic rv; logic [4:0] rid; logic [31:0] rd;
        int k, n;
        bus_xfer(c_a_tmo, 1'b0, 32'h0, 4'hF, 5'h01, rv, rid, rd);
        halted_i = 2'b01;
        bus_xfer(c_a_ctrl, 1'b0, 32'h1, 4'hF, 5'h02, rv, rid, rd);
        for (k = 0; k < 6 && halt_req_o !== 2'b11; k++) @(negedge clk_i);
        n = 0;
        while (halt_req_o === 2'b11 && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        n_checks++;
        if (n != 1 || err_irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo0_timeout: halt cycles=%0d irq=%b, want 1 1", n, err_irq_o);
        end
        // Counter already zero and both cores halted: the halt must win.
        halted_i = 2'b11;
        bus_xfer(c_a_ctrl, 1'b0, 32'h3, 4'hF, 5'h03, rv, rid, rd);
        for (k = 0; k < 6 && halt_req_o !== 2'b11; k++) @(negedge clk_i);
        n = 0;
        while (halt_req_o === 2'b11 && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        halted_i = 2'b00;
        n_checks++;
        if (n != 1 || resume_o !== 1'b1 || lockstep_en_o !== 1'b1 || err_irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo0_halted_wins: halt cycles=%0d res=%b en=%b irq=%b, want 1 1 1 0",
                     n, resume_o, lockstep_en_o, err_irq_o);
        end
        bus_xfer(c_a_ctrl, 1'b0, 32'h0, 4'hF, 5'h04, rv, rid, rd);
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        logic rv; logic [4:0] rid; logic [31:0] rd;
        int k, bad;
        bus_xfer(c_a_tmo, 1'b0, 32'hFF, 4'hF, 5'h01, rv, rid, rd);
        bus_xfer(c_a_ctrl, 1'b0, 32'h1, 4'hF, 5'h02, rv, rid, rd);
        for (k = 0; k < 6 && halt_req_o !== 2'b11; k++) @(negedge clk_i);
        halted_i = 2'b11;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (halt_req_o !== 2'b00 || resume_o !== 1'b0 || lockstep_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: halt=%b res=%b en=%b, want 00 0 0", halt_req_o, resume_o, lockstep_en_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (resume_o !== 1'b0 || halt_req_o !== 2'b00) bad++;
        end
        halted_i = 2'b00;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_no_resume: active cycles=%0d, want 0", bad);
        end
        bus_xfer(c_a_stat, 1'b1, 32'h0, 4'h0, 5'h03, rv, rid, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_status: data=%h, want 00000000", rd);
        end
    endtask

    task automatic test_random();
        int r, sel;
        logic [31:0] wd;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            n_checks++;
            if (halt_req_o !== ((m_mode == 1) ? 2'b11 : 2'b00) || resume_o !== e_resume ||
                lockstep_en_o !== (m_mode == 2) || err_irq_o !== m_err) begin
                n_fail++;
                $display("FAIL random_ctrl cyc %0d: halt=%b res=%b en=%b irq=%b, want mode %0d res=%b irq=%b",
                         i, halt_req_o, resume_o, lockstep_en_o, err_irq_o, m_mode, e_resume, m_err);
            end
            n_checks++;
            if (r_valid_o !== e_rvalid || (e_rvalid && (r_id_o !== e_rid || r_rdata_o !== e_rdata))) begin
                n_fail++;
                $display("FAIL random_resp cyc %0d: rv=%b id=%h data=%h, want %b %h %h",
                         i, r_valid_o, r_id_o, r_rdata_o, e_rvalid, e_rid, e_rdata);
            end
            r       = int'($urandom_range(0, 99));
            wd      = $urandom;
            req_i   = 1'b1;
            wen_i   = 1'b0;
            id_i    = 5'($urandom);
            be_i    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            if (r < 8) begin
                addr_i  = c_a_ctrl;
                wd[0]   = ($urandom_range(0, 3) != 0);
                wd[1]   = ($urandom_range(0, 3) == 0);
            end else if (r < 12) begin
                addr_i  = c_a_tmo;
                wd[7:0] = 8'($urandom_range(0, 6));
            end else if (r < 14) begin
                addr_i  = ($urandom_range(0, 1) == 0) ? c_a_stat : c_a_unmap;
            end else if (r < 30) begin
                sel     = int'($urandom_range(0, 3));
                addr_i  = c_base + 32'(sel * 4);
                wen_i   = 1'b1;
            end else begin
                req_i   = 1'b0;
            end
            wdata_i        = wd;
            halted_i       = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom);
            cmp_valid_i    = ($urandom_range(0, 2) == 0);
            cmp_mismatch_i = 1'($urandom_range(0, 1));
            model_step();
            @(negedge clk_i);
        end
        req_i = 1'b0; wen_i = 1'b0; be_i = '0; halted_i = '0;
        cmp_valid_i = 1'b0; cmp_mismatch_i = 1'b0;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_lock();
        test_mismatch();
        test_timeout();
        test_tmo_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
